id_stage: RTL and testbench

Instruction decode stage: the consumer end of the fetch interface. Latches `Instruction`/`PC` from the fetch stage into an IF/ID register. Decodes the latched instruction and reads operands from the register file. Resolves BEZ/BNE/JMP, drives `branch_taken`/`branch_address` back to fetch, squashes the wrong-path fetch, and issues decoded control into a registered ID/EX boundary for the execute stage.

---
 rtl/id_stage.sv | 202 ++++++++++++++++++++
 tb/tb_id_stage.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// Instruction decode stage: IF/ID register, operand read, branch resolution
// with one-bubble squash, and a registered ID/EX boundary for execute.
module id_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_instruction,
    input  logic [31:0] if_pc,
    output logic [4:0]  rs_addr,
    output logic [4:0]  rt_addr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        branch_taken,
    output logic [31:0] branch_address,
    output logic        ex_valid,
    output logic [3:0]  ex_alu_cmd,
    output logic [31:0] ex_val1,
    output logic [31:0] ex_val2,
    output logic [31:0] ex_st_val,
    output logic [4:0]  ex_dest,
    output logic        ex_wb_en,
    output logic        ex_mem_rd,
    output logic        ex_mem_wr,
    output logic        ill_op,
    output logic [31:0] issue_count
);

    localparam logic [5:0] OP_NOP  = 6'd0,  OP_ADD  = 6'd1,  OP_SUB  = 6'd3,
                           OP_AND  = 6'd5,  OP_OR   = 6'd6,  OP_NOR  = 6'd7,
                           OP_XOR  = 6'd8,  OP_SLA  = 6'd9,  OP_SLL  = 6'd10,
                           OP_SRA  = 6'd11, OP_SRL  = 6'd12, OP_ADDI = 6'd32,
                           OP_SUBI = 6'd33, OP_LD   = 6'd36, OP_ST   = 6'd37,
                           OP_BEZ  = 6'd40, OP_BNE  = 6'd41, OP_JMP  = 6'd42;

    localparam logic [3:0] CMD_NONE = 4'd0, CMD_ADD = 4'd1, CMD_SUB = 4'd2;

    // R-type opcodes map in listed order onto ALU commands 1..10
    function automatic logic [3:0] rtype_cmd(input logic [5:0] op);
        case (op)
            OP_ADD:  rtype_cmd = 4'd1;
            OP_SUB:  rtype_cmd = 4'd2;
            OP_AND:  rtype_cmd = 4'd3;
            OP_OR:   rtype_cmd = 4'd4;
            OP_NOR:  rtype_cmd = 4'd5;
            OP_XOR:  rtype_cmd = 4'd6;
            OP_SLA:  rtype_cmd = 4'd7;
            OP_SLL:  rtype_cmd = 4'd8;
            OP_SRA:  rtype_cmd = 4'd9;
            OP_SRL:  rtype_cmd = 4'd10;
            default: rtype_cmd = 4'd0;
        endcase
    endfunction

    logic [31:0] instr_q, pc_q;
    logic        valid_q;

    logic        ex_valid_q, ex_valid_d;
    logic [3:0]  ex_alu_cmd_q, ex_alu_cmd_d;
    logic [31:0] ex_val1_q, ex_val1_d, ex_val2_q, ex_val2_d, ex_st_val_q, ex_st_val_d;
    logic [4:0]  ex_dest_q, ex_dest_d;
    logic        ex_wb_en_q, ex_wb_en_d, ex_mem_rd_q, ex_mem_rd_d, ex_mem_wr_q, ex_mem_wr_d;
    logic        ill_op_q, ill_op_d;
    logic [31:0] issue_count_q, issue_count_d;

    logic [5:0]  op_s;
    logic [31:0] sext_s;
    logic        wb_raw_s, illegal_s, taken_s;

    assign op_s           = instr_q[31:26];
    assign sext_s         = {{16{instr_q[15]}}, instr_q[15:0]};
    assign rs_addr        = instr_q[25:21];
    assign rt_addr        = instr_q[20:16];
    assign branch_taken   = taken_s;
    assign branch_address = pc_q + 32'd4 + {sext_s[29:0], 2'b00};

    // Decode the IF/ID instruction into next ID/EX contents and branch outcome
    always_comb begin
        ex_valid_d   = 1'b0;
        ex_alu_cmd_d = CMD_NONE;
        ex_val1_d    = 32'd0;
        ex_val2_d    = 32'd0;
        ex_st_val_d  = 32'd0;
        ex_dest_d    = 5'd0;
        ex_mem_rd_d  = 1'b0;
        ex_mem_wr_d  = 1'b0;
        wb_raw_s     = 1'b0;
        illegal_s    = 1'b0;
        taken_s      = 1'b0;
        if (valid_q) begin
            case (op_s)
                OP_NOP: begin
                    ex_valid_d = 1'b0;
                end
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR,
                OP_XOR, OP_SLA, OP_SLL, OP_SRA, OP_SRL: begin
                    ex_valid_d   = 1'b1;
                    ex_alu_cmd_d = rtype_cmd(op_s);
                    ex_val1_d    = rs_data;
                    ex_val2_d    = rt_data;
                    ex_dest_d    = instr_q[15:11];
                    wb_raw_s     = 1'b1;
                end
                OP_ADDI, OP_SUBI, OP_LD: begin
                    ex_valid_d   = 1'b1;
                    ex_alu_cmd_d = (op_s == OP_SUBI) ? CMD_SUB : CMD_ADD;
                    ex_val1_d    = rs_data;
                    ex_val2_d    = sext_s;
                    ex_dest_d    = instr_q[20:16];
                    ex_mem_rd_d  = (op_s == OP_LD);
                    wb_raw_s     = 1'b1;
                end
                OP_ST: begin
                    ex_valid_d   = 1'b1;
                    ex_alu_cmd_d = CMD_ADD;
                    ex_val1_d    = rs_data;
                    ex_val2_d    = sext_s;
                    ex_st_val_d  = rt_data;
                    ex_mem_wr_d  = 1'b1;
                end
                OP_BEZ: begin
                    ex_valid_d = 1'b1;
                    taken_s    = (rs_data == 32'd0);
                end
                OP_BNE: begin
                    ex_valid_d = 1'b1;
                    taken_s    = (rs_data != rt_data);
                end
                OP_JMP: begin
                    ex_valid_d = 1'b1;
                    taken_s    = 1'b1;
                end
                default: begin
                    illegal_s = 1'b1;
                end
            endcase
        end else begin
            illegal_s = 1'b0;
        end
        // r0 is hardwired; never request a write to it
        ex_wb_en_d    = wb_raw_s & (ex_dest_d != 5'd0);
        ill_op_d      = ill_op_q | illegal_s;
        issue_count_d = issue_count_q + {31'd0, ex_valid_d};
    end

    // IF/ID register: a taken branch squashes the wrong-path fetch
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= 32'd0;
            pc_q    <= 32'd0;
            valid_q <= 1'b0;
        end else if (taken_s) begin
            instr_q <= 32'd0;
            pc_q    <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= if_instruction;
            pc_q    <= if_pc;
            valid_q <= 1'b1;
        end
    end

    // ID/EX register plus sticky illegal flag and issue counter
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q    <= 1'b0;
            ex_alu_cmd_q  <= 4'd0;
            ex_val1_q     <= 32'd0;
            ex_val2_q     <= 32'd0;
            ex_st_val_q   <= 32'd0;
            ex_dest_q     <= 5'd0;
            ex_wb_en_q    <= 1'b0;
            ex_mem_rd_q   <= 1'b0;
            ex_mem_wr_q   <= 1'b0;
            ill_op_q      <= 1'b0;
            issue_count_q <= 32'd0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_alu_cmd_q  <= ex_alu_cmd_d;
            ex_val1_q     <= ex_val1_d;
            ex_val2_q     <= ex_val2_d;
            ex_st_val_q   <= ex_st_val_d;
            ex_dest_q     <= ex_dest_d;
            ex_wb_en_q    <= ex_wb_en_d;
            ex_mem_rd_q   <= ex_mem_rd_d;
            ex_mem_wr_q   <= ex_mem_wr_d;
            ill_op_q      <= ill_op_d;
            issue_count_q <= issue_count_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_alu_cmd  = ex_alu_cmd_q;
    assign ex_val1     = ex_val1_q;
    assign ex_val2     = ex_val2_q;
    assign ex_st_val   = ex_st_val_q;
    assign ex_dest     = ex_dest_q;
    assign ex_wb_en    = ex_wb_en_q;
    assign ex_mem_rd   = ex_mem_rd_q;
    assign ex_mem_wr   = ex_mem_wr_q;
    assign ill_op      = ill_op_q;
    assign issue_count = issue_count_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage: decode, branch/squash, ill_op, reset.
module tb_id_stage;

    logic        clk, rst;
    logic [31:0] if_instruction, if_pc, rs_data, rt_data;
    logic [4:0]  rs_addr, rt_addr;
    logic        branch_taken;
    logic [31:0] branch_address;
    logic        ex_valid;
    logic [3:0]  ex_alu_cmd;
    logic [31:0] ex_val1, ex_val2, ex_st_val;
    logic [4:0]  ex_dest;
    logic        ex_wb_en, ex_mem_rd, ex_mem_wr, ill_op;
    logic [31:0] issue_count;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_cnt = 32'd0;
    logic [12:0] ctrl_s;

    id_stage dut (
        .clk(clk), .rst(rst),
        .if_instruction(if_instruction), .if_pc(if_pc),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data),
        .branch_taken(branch_taken), .branch_address(branch_address),
        .ex_valid(ex_valid), .ex_alu_cmd(ex_alu_cmd),
        .ex_val1(ex_val1), .ex_val2(ex_val2), .ex_st_val(ex_st_val),
        .ex_dest(ex_dest), .ex_wb_en(ex_wb_en), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
        .ill_op(ill_op), .issue_count(issue_count)
    );

    assign ctrl_s = {ex_valid, ex_alu_cmd, ex_dest, ex_wb_en, ex_mem_rd, ex_mem_wr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; if_instruction = 32'h8001060A; if_pc = 32'h40; rs_data = 32'd0; rt_data = 32'd0;
        step(); step();
        n_cmp++; if (ctrl_s !== 13'd0) begin n_err++; $display("FAIL reset_ctrl got %h want 0", ctrl_s); end
        n_cmp++; if ({ex_val1, ex_val2, ex_st_val} !== 96'd0) begin n_err++; $display("FAIL reset_vals got %h %h %h want 0", ex_val1, ex_val2, ex_st_val); end
        n_cmp++; if (issue_count !== 32'd0 || ill_op !== 1'b0) begin n_err++; $display("FAIL reset_cnt got %0d ill %b want 0 0", issue_count, ill_op); end
        n_cmp++; if (branch_taken !== 1'b0 || branch_address !== 32'd4) begin n_err++; $display("FAIL reset_branch got %b %h want 0 4", branch_taken, branch_address); end
    endtask

    task automatic test_addi();
        rst = 1'b0; if_instruction = 32'h8001060A; if_pc = 32'h0;
        step();
        if_instruction = 32'h0; rs_data = 32'd0;
        n_cmp++; if (rs_addr !== 5'd0 || rt_addr !== 5'd1) begin n_err++; $display("FAIL addi_addr got %0d %0d want 0 1", rs_addr, rt_addr); end
        step(); exp_cnt++;
        n_cmp++; if (ctrl_s !== {1'b1, 4'd1, 5'd1, 1'b1, 1'b0, 1'b0}) begin n_err++; $display("FAIL addi_ctrl got %h want %h", ctrl_s, {1'b1, 4'd1, 5'd1, 3'b100}); end
        n_cmp++; if (ex_val1 !== 32'd0 || ex_val2 !== 32'h0000060A) begin n_err++; $display("FAIL addi_vals got %h %h want 0 60a", ex_val1, ex_val2); end
        n_cmp++; if (issue_count !== 32'd1) begin n_err++; $display("FAIL addi_cnt got %0d want 1", issue_count); end
    endtask

    task automatic test_bez();
        // taken: the ADDI fetched behind it must be squashed
        if_instruction = 32'hA0A00001; if_pc = 32'h5C;
        step();
        rs_data = 32'd0; if_instruction = 32'h8001060A; if_pc = 32'h60; #1;
        n_cmp++; if (branch_taken !== 1'b1 || branch_address !== 32'h64) begin n_err++; $display("FAIL bez_taken got %b %h want 1 64", branch_taken, branch_address); end
        n_cmp++; if (rs_addr !== 5'd5) begin n_err++; $display("FAIL bez_rs got %0d want 5", rs_addr); end
        step(); exp_cnt++;
        if_instruction = 32'h0;
        n_cmp++; if (ctrl_s !== {1'b1, 12'd0}) begin n_err++; $display("FAIL bez_issue got %h want %h", ctrl_s, {1'b1, 12'd0}); end
        n_cmp++; if (branch_taken !== 1'b0) begin n_err++; $display("FAIL bez_squash_bt got %b want 0", branch_taken); end
        step();
        n_cmp++; if (ex_valid !== 1'b0 || issue_count !== exp_cnt) begin n_err++; $display("FAIL bez_bubble got %b %0d want 0 %0d", ex_valid, issue_count, exp_cnt); end
        // not taken: the following ADDI must issue
        if_instruction = 32'hA0A00001; if_pc = 32'h5C;
        step();
        rs_data = 32'd1546; if_instruction = 32'h8001060A; if_pc = 32'h60; #1;
        n_cmp++; if (branch_taken !== 1'b0) begin n_err++; $display("FAIL bez_nt got %b want 0", branch_taken); end
        step(); exp_cnt++;
        rs_data = 32'd0; if_instruction = 32'h0;
        step(); exp_cnt++;
        n_cmp++; if (ctrl_s !== {1'b1, 4'd1, 5'd1, 1'b1, 1'b0, 1'b0} || issue_count !== exp_cnt) begin n_err++; $display("FAIL bez_nt_next got %h %0d want %h %0d", ctrl_s, issue_count, {1'b1, 4'd1, 5'd1, 3'b100}, exp_cnt); end
    endtask

    task automatic test_bne();
        if_instruction = 32'hA423FFF1; if_pc = 32'h130;
        step();
        if_instruction = 32'h0; rs_data = 32'd3; rt_data = 32'd2; #1;
        n_cmp++; if (branch_taken !== 1'b1 || branch_address !== 32'hF8) begin n_err++; $display("FAIL bne_taken got %b %h want 1 f8", branch_taken, branch_address); end
        rt_data = 32'd3; #1;
        n_cmp++; if (branch_taken !== 1'b0) begin n_err++; $display("FAIL bne_nt got %b want 0", branch_taken); end
        step(); exp_cnt++;
        n_cmp++; if (ctrl_s !== {1'b1, 12'd0}) begin n_err++; $display("FAIL bne_issue got %h want %h", ctrl_s, {1'b1, 12'd0}); end
        rs_data = 32'd0; rt_data = 32'd0;
    endtask

    task automatic test_back_to_back_jmp();
        if_instruction = 32'hA800FFFF; if_pc = 32'h180;
        step();
        n_cmp++; if (branch_taken !== 1'b1 || branch_address !== 32'h180) begin n_err++; $display("FAIL jmp_target got %b %h want 1 180", branch_taken, branch_address); end
        for (int i = 0; i < 4; i++) begin
            step();
            if (i % 2 == 0) exp_cnt++;
            n_cmp++; if (ex_valid !== (i % 2 == 0) || branch_taken !== (i % 2 == 1)) begin n_err++; $display("FAIL jmp_alt%0d got v%b bt%b want v%b bt%b", i, ex_valid, branch_taken, (i % 2 == 0), (i % 2 == 1)); end
        end
        if_instruction = 32'h0;
        step(); exp_cnt++;
        step();
        n_cmp++; if (issue_count !== exp_cnt) begin n_err++; $display("FAIL jmp_cnt got %0d want %0d", issue_count, exp_cnt); end
    endtask

    task automatic test_rtype_mem();
        if_instruction = 32'h20A10000;
        step();
        rs_data = 32'd11; rt_data = 32'd22; if_instruction = 32'h94270014;
        step(); exp_cnt++;
        n_cmp++; if (ctrl_s !== {1'b1, 4'd6, 5'd0, 3'b000} || ex_val1 !== 32'd11 || ex_val2 !== 32'd22) begin n_err++; $display("FAIL xor_r0 got %h %0d %0d want %h 11 22", ctrl_s, ex_val1, ex_val2, {1'b1, 4'd6, 8'd0}); end
        rs_data = 32'd100; rt_data = 32'hFFFFE7D8; if_instruction = 32'h90220008;
        step(); exp_cnt++;
        n_cmp++; if (ctrl_s !== {1'b1, 4'd1, 5'd0, 3'b001} || ex_val1 !== 32'd100 || ex_val2 !== 32'd20 || ex_st_val !== 32'hFFFFE7D8) begin n_err++; $display("FAIL st got %h %h %h %h want %h 64 14 ffffe7d8", ctrl_s, ex_val1, ex_val2, ex_st_val, {1'b1, 4'd1, 5'd0, 3'b001}); end
        rs_data = 32'd7; rt_data = 32'd0; if_instruction = 32'h8483FFFF;
        step(); exp_cnt++;
        n_cmp++; if (ctrl_s !== {1'b1, 4'd1, 5'd2, 3'b110} || ex_val2 !== 32'd8 || ex_st_val !== 32'd0) begin n_err++; $display("FAIL ld got %h %h %h want %h 8 0", ctrl_s, ex_val2, ex_st_val, {1'b1, 4'd1, 5'd2, 3'b110}); end
        rs_data = 32'd5; if_instruction = 32'h0;
        step(); exp_cnt++;
        n_cmp++; if (ctrl_s !== {1'b1, 4'd2, 5'd3, 3'b100} || ex_val1 !== 32'd5 || ex_val2 !== 32'hFFFFFFFF) begin n_err++; $display("FAIL subi got %h %h %h want %h 5 ffffffff", ctrl_s, ex_val1, ex_val2, {1'b1, 4'd2, 5'd3, 3'b100}); end
        rs_data = 32'd0;
    endtask

    task automatic test_illegal();
        if_instruction = 32'hFC000000;
        step();
        if_instruction = 32'h0;
        n_cmp++; if (ill_op !== 1'b0) begin n_err++; $display("FAIL ill_early got %b want 0", ill_op); end
        step();
        n_cmp++; if (ex_valid !== 1'b0 || ill_op !== 1'b1 || issue_count !== exp_cnt) begin n_err++; $display("FAIL ill_set got v%b ill%b cnt%0d want 0 1 %0d", ex_valid, ill_op, issue_count, exp_cnt); end
        step(); step();
        n_cmp++; if (ill_op !== 1'b1) begin n_err++; $display("FAIL ill_hold got %b want 1", ill_op); end
    endtask

    task automatic test_reset_midstream();
        if_instruction = 32'hA800FFFF; if_pc = 32'h180;
        step();
        rst = 1'b1; if_instruction = 32'h8001060A; if_pc = 32'h200;
        step();
        n_cmp++; if (ctrl_s !== 13'd0 || issue_count !== 32'd0 || ill_op !== 1'b0) begin n_err++; $display("FAIL rst_mid got %h cnt%0d ill%b want 0 0 0", ctrl_s, issue_count, ill_op); end
        n_cmp++; if (branch_taken !== 1'b0 || branch_address !== 32'd4) begin n_err++; $display("FAIL rst_mid_br got %b %h want 0 4", branch_taken, branch_address); end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_bez();
        test_bne();
        test_back_to_back_jmp();
        test_rtype_mem();
        test_illegal();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
